// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift/correct step per clock.
// Optional leading-zero blank output is enabled by defining BIN_TO_BCD_BLANK_EN.

module bin_to_bcd_digit (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bin_to_bcd_seq #(
   parameter int BIN_WIDTH  = 16,
   parameter int DEC_DIGITS = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BIN_WIDTH-1:0]    bin,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DEC_DIGITS*4-1:0] bcd,
   output logic                    overflow
`ifdef BIN_TO_BCD_BLANK_EN
   ,
   output logic [DEC_DIGITS-1:0]   blank
`endif
);
   localparam int CW = $clog2(BIN_WIDTH + 1);
   localparam int AW = DEC_DIGITS * 4;
   localparam logic [CW-1:0] CNT_INIT = CW'(BIN_WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state, state_nx;
   logic [BIN_WIDTH-1:0] sreg;
   logic [AW-1:0]        acc, acc_adj;
   logic [CW-1:0]        cnt;
   logic                 ovf;

   for (genvar i = 0; i < DEC_DIGITS; i++) begin : g_dig
      bin_to_bcd_digit u_dig (.din(acc[4*i +: 4]), .dout(acc_adj[4*i +: 4]));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = SHIFT;
         SHIFT:   if (cnt == CW'(1)) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
         acc  <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sreg <= bin;
               acc  <= '0;
               cnt  <= CNT_INIT;
               ovf  <= 1'b0;
            end
            SHIFT: begin
               // the corrected top bit falls off the accumulator: value no longer fits
               {acc, sreg} <= {acc_adj[AW-2:0], sreg, 1'b0};
               ovf         <= ovf | acc_adj[AW-1];
               cnt         <= cnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign overflow  = ovf;
   assign bcd       = ovf ? {DEC_DIGITS{4'h9}} : acc;

`ifdef BIN_TO_BCD_BLANK_EN
   assign blank[0] = 1'b0;
   for (genvar i = 1; i < DEC_DIGITS; i++) begin : g_blank
      assign blank[i] = out_valid && !ovf && (acc[AW-1:4*i] == '0);
   end
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench driving three converter instances (16/5, 8/3, 16/4) from shared stimulus,
// checked against an arithmetic decimal reference.

module tb_bin_to_bcd_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready;
   logic [15:0] bin;

   logic        a_in_ready, a_out_valid, a_ovf;
   logic [19:0] a_bcd;
   logic        b_in_ready, b_out_valid, b_ovf;
   logic [11:0] b_bcd;
   logic        c_in_ready, c_out_valid, c_ovf;
   logic [15:0] c_bcd;
`ifdef BIN_TO_BCD_BLANK_EN
   logic [4:0]  a_blank;
   logic [2:0]  b_blank;
   logic [3:0]  c_blank;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_WIDTH(16), .DEC_DIGITS(5)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .bin(bin),
      .out_valid(a_out_valid), .out_ready(out_ready), .bcd(a_bcd), .overflow(a_ovf)
`ifdef BIN_TO_BCD_BLANK_EN
      , .blank(a_blank)
`endif
   );

   bin_to_bcd_seq #(.BIN_WIDTH(8), .DEC_DIGITS(3)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .bin(bin[7:0]),
      .out_valid(b_out_valid), .out_ready(out_ready), .bcd(b_bcd), .overflow(b_ovf)
`ifdef BIN_TO_BCD_BLANK_EN
      , .blank(b_blank)
`endif
   );

   bin_to_bcd_seq #(.BIN_WIDTH(16), .DEC_DIGITS(4)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready), .bin(bin),
      .out_valid(c_out_valid), .out_ready(out_ready), .bcd(c_bcd), .overflow(c_ovf)
`ifdef BIN_TO_BCD_BLANK_EN
      , .blank(c_blank)
`endif
   );

   function automatic longint pow10(input int d);
      longint p = 1;
      for (int i = 0; i < d; i++) p *= 10;
      return p;
   endfunction

   function automatic logic [31:0] ref_bcd(input longint v, input int d);
      logic [31:0] r = '0;
      longint      x = v;
      if (v >= pow10(d)) begin
         for (int i = 0; i < d; i++) r[4*i +: 4] = 4'h9;
      end else begin
         for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] ref_blank(input longint v, input int d);
      logic [7:0] r = '0;
      if (v >= pow10(d)) return r;
      for (int i = 1; i < d; i++) r[i] = (v < pow10(i));
      return r;
   endfunction

   // One conversion through all three instances; optional output backpressure and
   // an in_valid pulse while the converters are busy.
   task automatic convert(input logic [15:0] v, input int hold, input bit pulse);
      logic [19:0] ea;
      logic [11:0] eb;
      logic [15:0] ec;
      logic        oa, ob, oc;
      int          cyc, la, lb, lc;
      ea = 20'(ref_bcd(v, 5));
      eb = 12'(ref_bcd(v[7:0], 3));
      ec = 16'(ref_bcd(v, 4));
      oa = (v >= pow10(5));
      ob = (v[7:0] >= pow10(3));
      oc = (v >= pow10(4));
      @(posedge clk); #1;
      total++;
      if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111) begin
         bad++; $display("FAIL idle_ready got=%b exp=111", {a_in_ready, b_in_ready, c_in_ready});
      end
      bin = v; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; bin = 16'($urandom);
      cyc = 0; la = -1; lb = -1; lc = -1;
      while (!(a_out_valid && b_out_valid && c_out_valid) && cyc < 100) begin
         in_valid = pulse && (cyc >= 3) && (cyc <= 5);
         @(posedge clk); #1;
         cyc++;
         if (a_out_valid && la < 0) la = cyc;
         if (b_out_valid && lb < 0) lb = cyc;
         if (c_out_valid && lc < 0) lc = cyc;
      end
      in_valid = 1'b0;
      total++;
      if (la != 16 || lb != 8 || lc != 16) begin
         bad++; $display("FAIL latency v=%0d got=%0d/%0d/%0d exp=16/8/16", v, la, lb, lc);
      end
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) begin @(posedge clk); #1; end
         total++;
         if (a_bcd !== ea || a_ovf !== oa) begin
            bad++; $display("FAIL a_result v=%0d h=%0d got=%h/%b exp=%h/%b", v, h, a_bcd, a_ovf, ea, oa);
         end
         total++;
         if (b_bcd !== eb || b_ovf !== ob) begin
            bad++; $display("FAIL b_result v=%0d h=%0d got=%h/%b exp=%h/%b", v, h, b_bcd, b_ovf, eb, ob);
         end
         total++;
         if (c_bcd !== ec || c_ovf !== oc) begin
            bad++; $display("FAIL c_result v=%0d h=%0d got=%h/%b exp=%h/%b", v, h, c_bcd, c_ovf, ec, oc);
         end
         total++;
         if ({a_out_valid, b_out_valid, c_out_valid, a_in_ready, b_in_ready, c_in_ready} !== 6'b111000) begin
            bad++; $display("FAIL done_hold v=%0d h=%0d got=%b exp=111000", v, h,
               {a_out_valid, b_out_valid, c_out_valid, a_in_ready, b_in_ready, c_in_ready});
         end
`ifdef BIN_TO_BCD_BLANK_EN
         total++;
         if (a_blank !== 5'(ref_blank(v, 5)) || b_blank !== 3'(ref_blank(v[7:0], 3)) ||
             c_blank !== 4'(ref_blank(v, 4))) begin
            bad++; $display("FAIL blank v=%0d got=%b/%b/%b exp=%b/%b/%b", v, a_blank, b_blank, c_blank,
               5'(ref_blank(v, 5)), 3'(ref_blank(v[7:0], 3)), 4'(ref_blank(v, 4)));
         end
`endif
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if ({a_out_valid, b_out_valid, c_out_valid, a_in_ready, b_in_ready, c_in_ready} !== 6'b000111) begin
         bad++; $display("FAIL release v=%0d got=%b exp=000111", v,
            {a_out_valid, b_out_valid, c_out_valid, a_in_ready, b_in_ready, c_in_ready});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bin = '0;
      #3;
      total++;
      if ({a_in_ready, b_in_ready, c_in_ready, a_out_valid, b_out_valid, c_out_valid} !== 6'b111000 ||
          a_bcd !== '0 || b_bcd !== '0 || c_bcd !== '0 || {a_ovf, b_ovf, c_ovf} !== 3'b000) begin
         bad++; $display("FAIL reset_state got=%b %h %h %h %b", {a_in_ready, b_in_ready, c_in_ready,
            a_out_valid, b_out_valid, c_out_valid}, a_bcd, b_bcd, c_bcd, {a_ovf, b_ovf, c_ovf});
      end
`ifdef BIN_TO_BCD_BLANK_EN
      total++;
      if (a_blank !== '0 || b_blank !== '0 || c_blank !== '0) begin
         bad++; $display("FAIL reset_blank got=%b/%b/%b exp=0", a_blank, b_blank, c_blank);
      end
`endif
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_vectors();
      convert(16'd243,   0, 1'b0);
      convert(16'hFFFF,  0, 1'b0);
      convert(16'd0,     0, 1'b0);
      convert(16'd12345, 0, 1'b0);
      convert(16'd9999,  0, 1'b0);
      convert(16'd42,    0, 1'b0);
      convert(16'd60000, 0, 1'b0);
      convert(16'd1000,  0, 1'b0);
      convert(16'd999,   0, 1'b0);
   endtask

   task automatic test_backpressure();
      convert(16'd31415, 5, 1'b1);
      convert(16'd7,     3, 1'b1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 25; n++) convert(16'($urandom), n % 3, n[0]);
   endtask

   task automatic test_mid_reset();
      @(posedge clk); #1;
      bin = 16'd54321; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if ({a_in_ready, b_in_ready, c_in_ready, a_out_valid, b_out_valid, c_out_valid} !== 6'b111000 ||
          a_bcd !== '0 || b_bcd !== '0 || c_bcd !== '0) begin
         bad++; $display("FAIL mid_reset got=%b %h %h %h exp=111000 0 0 0", {a_in_ready, b_in_ready,
            c_in_ready, a_out_valid, b_out_valid, c_out_valid}, a_bcd, b_bcd, c_bcd);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         total++;
         if ({a_out_valid, b_out_valid, c_out_valid} !== 3'b000) begin
            bad++; $display("FAIL stale_valid k=%0d got=%b exp=000", k, {a_out_valid, b_out_valid, c_out_valid});
         end
      end
      convert(16'd100, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_random();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end
endmodule
